// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and helpers for the programmable sequence detector.
//   - state_t  : detector FSM state (FILL while history is short, HUNT once armed)
//   - len_w()  : width needed to hold a pattern length of 0..max_len
//   - len_mask(): right-aligned mask of n ones used to ignore compare bits above len
package seq_det_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HUNT = 1'b1
    } state_t;

    // Upper bound on the mask the helper can build; callers size-cast the result.
    localparam int MASK_W = 64;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [MASK_W-1:0] len_mask(input int n);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// seq_shift_cmp
//   History shift register, masked pattern compare and fill counter.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clr        : clear history and fill count (accepted config write)
//     shift      : sample din on this edge
//     restart    : zero the fill count on this shift (non-overlapping match)
//     din        : serial data bit
//     pattern    : right-aligned pattern, bit [len-1] is the oldest bit
//     len        : active pattern length
//     hit        : combinational, the bit being shifted in completes a match
//     fill_full  : combinational, after this shift at least len bits are held
module seq_shift_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           shift,
    input  logic                           restart,
    input  logic                           din,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    output logic                           hit,
    output logic                           fill_full
);

    localparam int LW = len_w(MAX_LEN);
    localparam logic [LW:0] INC_ONE = (LW+1)'(1);

    // Only MAX_LEN-1 past bits need storing: the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_cnt;
    logic [LW:0]        fill_inc;

    always_comb begin
        hist_nxt  = {hist, din};
        mask      = MAX_LEN'(len_mask(int'(len)));
        fill_inc  = {1'b0, fill_cnt} + INC_ONE;
        fill_full = (fill_inc >= {1'b0, len});
        hit       = shift && fill_full && ((hist_nxt & mask) == (pattern & mask));
    end

    // Fill count saturates at len; a non-overlapping match restarts it so the
    // next match has to be built from len fresh bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist     <= '0;
            fill_cnt <= '0;
        end else if (shift) begin
            hist <= hist_nxt[MAX_LEN-2:0];
            if (restart) begin
                fill_cnt <= '0;
            end else if (fill_cnt < len) begin
                fill_cnt <= fill_inc[LW-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog
//   Runtime-programmable serial sequence detector with overlap/non-overlap mode.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     din          : serial data bit, sampled when din_valid is high
//     din_valid    : data qualifier
//     cfg_we       : config write strobe (takes priority over din on the same edge)
//     cfg_pattern  : right-aligned pattern, bit [len-1] received first
//     cfg_len      : pattern length, legal range 1..MAX_LEN
//     cfg_overlap  : 1 = overlapping matches, 0 = non-overlapping
//     cnt_clr      : clear the match counter
//     dout         : registered one-cycle match pulse
//     match_cnt    : saturating match counter
//     cfg_err      : one-cycle pulse when a config write is rejected
//     armed        : enough history held to match (FSM in HUNT)
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           din,
    input  logic                           din_valid,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           dout,
    output logic [CNT_W-1:0]               match_cnt,
    output logic                           cfg_err,
    output logic                           armed
);

    localparam int               LW        = len_w(MAX_LEN);
    localparam logic [LW-1:0]    MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0]      len_q;
    logic               overlap_q;
    state_t             state;

    logic cfg_legal;
    logic load;
    logic shift;
    logic restart;
    logic hit;
    logic fill_full;

    // A config write on the same edge as valid data discards that data bit,
    // whether or not the write is accepted.
    always_comb begin
        cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
        load      = cfg_we && cfg_legal;
        shift     = din_valid && !cfg_we;
        restart   = hit && !overlap_q;
    end

    seq_shift_cmp #(
        .MAX_LEN (MAX_LEN)
    ) u_shift_cmp (
        .clk       (clk),
        .rst       (rst),
        .clr       (load),
        .shift     (shift),
        .restart   (restart),
        .din       (din),
        .pattern   (pattern_q),
        .len       (len_q),
        .hit       (hit),
        .fill_full (fill_full)
    );

    // Config, FSM, match pulse, counter and error pulse. cnt_clr coincident with
    // a match leaves the counter at one so that match is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            state     <= FILL;
            dout      <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            dout    <= hit;
            cfg_err <= cfg_we && !cfg_legal;

            if (load) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                state     <= FILL;
            end else if (shift) begin
                case (state)
                    FILL:    if (fill_full && !restart) state <= HUNT;
                    HUNT:    if (restart) state <= FILL;
                    default: state <= FILL;
                endcase
            end

            if (cnt_clr) begin
                match_cnt <= hit ? CNT_ONE : '0;
            end else if (hit && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_ONE;
            end
        end
    end

    assign armed = (state == HUNT);

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Runtime-programmable serial sequence detector, the parametrised successor to the team's fixed-pattern 4-bit Mealy detectors (1010/1101/1001/1011).
- Pattern, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded through a config port.
- Input bits arrive with a valid qualifier.
- Produces a registered one-cycle match pulse and a saturating match counter.
- Sits behind serial front-ends as a reusable framing/marker detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- DEF_PATTERN, 8'b0000_1011, reset pattern, right-aligned.
- DEF_LEN, 4, reset pattern length.
- DEF_OVERLAP, 1, reset mode (1 = overlapping).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled on this edge only when high.
- cfg_we  in  1  config write strobe.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  clear match counter.
- dout  out  1  match pulse.
- match_cnt  out  CNT_W  saturating number of matches.
- cfg_err  out  1  one-cycle pulse when a cfg write is rejected.
- armed  out  1  high when fill_cnt >= len, i.e. state HUNT.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP;
  - hist=0, fill_cnt=0, state=FILL;
  - dout=0, match_cnt=0, cfg_err=0.
  - Reset mid-stream discards partial history.
- Internal state:
  - hist: MAX_LEN shift register, hist_nxt = {hist[MAX_LEN-2:0], din}.
  - fill_cnt: saturates at len.
- FSM, two states:
  - FILL: fewer than len valid bits since last clear.
  - HUNT: at least len bits held.
  - FILL->HUNT when fill_cnt reaches len.
  - HUNT->FILL on non-overlap match or on config write.
- Match condition, on an edge with din_valid=1:
  - (fill_cnt+1 >= len) and hist_nxt[len-1:0] == pattern[len-1:0].
  - Compare bits above len are masked.
- Latency and width of dout:
  - dout is registered: high for exactly the one cycle following the edge that sampled the completing bit.
  - dout=0 on any edge with din_valid=0.
- Overlap mode: history is retained after a match; for len=1, consecutive matching bits give consecutive dout pulses.
- Non-overlap mode: on a match, fill_cnt<=0 and state<=FILL, so the next match needs len fresh bits.
- din_valid=0: hist, fill_cnt and state hold; gaps are transparent to detection.
- Config write (cfg_we=1):
  - Legal when 1 <= cfg_len <= MAX_LEN: load pattern, len and overlap; clear hist and fill_cnt; state=FILL; match_cnt unchanged.
  - Illegal len: config unchanged, history unchanged, cfg_err=1 for one cycle.
- cfg_we and din_valid in the same cycle: config wins. That din is discarded and dout=0, including when the config is rejected.
- match_cnt:
  - Increments on each match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr alone: 0.
  - cnt_clr coincident with a match: 1, so the match is not lost.
- Mode changes take effect only via cfg_we; cfg_* inputs are ignored otherwise.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {FILL, HUNT};
  - function len_w(MAX_LEN) = $clog2(MAX_LEN+1);
  - a mask-generation function producing len ones, right-aligned.
- One sub-module, seq_shift_cmp:
  - Contains the history shift register, masked compare and fill counter.
  - Outputs a combinational hit and fill_full.
- Top level holds config registers, FSM, dout register, counter and cfg_err.

Test Plan:
- Defaults (1011, len 4, overlap) after reset; stream 1,0,1,1,0,1,1 all valid -> dout pulses after bits 4 and 7; match_cnt=2.
- cfg pattern=1011, len=4, overlap=0; same stream -> single pulse after bit 4; match_cnt=1.
- Pattern 1011 with din_valid gaps: 1,(gap),0,1,(gap x3),1 -> one pulse, on the cycle after the final valid 1.
- Mid-stream reconfig: feed 1,0,1, then cfg pattern=1010, len=4 with din_valid=1 in the same cycle.
  - Required: that bit dropped, no pulse.
  - Then 1,0,1,0 -> pulse after the 4th bit.
- cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulse each, config and detection unchanged (1011 still matches).
- CNT_W=2, len=1, pattern=1, overlap=1; stream of 5 ones -> 5 consecutive dout cycles, match_cnt stops at 3.
  - Then cnt_clr together with a matching bit -> match_cnt=1.
